// File: rtl/stand_light_pwm_ctrl_if.sv
// Stand-light controller bus: slow clock and button in, LED drive and level out.
// The master side (clock divider / button / bench) drives the inputs, the
// controller itself is the slave.
interface stand_light_pwm_ctrl_if;
    logic       i_slow_clk;
    logic       i_btn;
    logic       o_light;
    logic [2:0] o_mode;

    modport master (
        output i_slow_clk,
        output i_btn,
        input  o_light,
        input  o_mode
    );

    modport slave (
        input  i_slow_clk,
        input  i_btn,
        output o_light,
        output o_mode
    );
endinterface

// File: rtl/stand_light_pwm_ctrl.sv
// Stand-light PWM controller.
// The divided slow clock is sampled as data and turned into a one-cycle tick.
// A debounced push-button steps a five-level brightness FSM
// (OFF, 25%, 50%, 75%, 100%), and the chosen level is rendered as tick-rate
// PWM on o_light. Duty changes only at a period wrap so no partial periods
// are ever emitted.
// Optional feature macro AUTO_OFF_EN: when defined, an idle counter returns
// the light to OFF after AUTO_OFF_TICKS ticks without a press.
module stand_light_pwm_ctrl #(
    parameter int PWM_PERIOD     = 10,
    parameter int DEBOUNCE_TICKS = 4
`ifdef AUTO_OFF_EN
    ,
    parameter int AUTO_OFF_TICKS = 1000
`endif
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    stand_light_pwm_ctrl_if.slave        bus
);

    localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int DEB_W  = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    localparam logic [DUTY_W-1:0] DUTY_25  = DUTY_W'((PWM_PERIOD * 1) / 4);
    localparam logic [DUTY_W-1:0] DUTY_50  = DUTY_W'((PWM_PERIOD * 2) / 4);
    localparam logic [DUTY_W-1:0] DUTY_75  = DUTY_W'((PWM_PERIOD * 3) / 4);
    localparam logic [DUTY_W-1:0] DUTY_100 = DUTY_W'(PWM_PERIOD);

    typedef enum logic [2:0] {
        MODE_OFF = 3'd0,
        MODE_25  = 3'd1,
        MODE_50  = 3'd2,
        MODE_75  = 3'd3,
        MODE_100 = 3'd4
    } mode_t;

    logic              slow_s1;
    logic              slow_s2;
    logic              slow_s3;
    logic              tick;

    logic              btn_s1;
    logic              btn_s2;
    logic              btn_stable;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_accept;
    logic              rise_accept;
    logic              press;

    mode_t             state;
    mode_t             state_next;
    logic [2:0]        mode_out;
    logic              timeout;

    logic [CNT_W-1:0]  pwm_cnt;
    logic [CNT_W-1:0]  pwm_cnt_next;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] duty_target;
    logic              wrap;
    logic              light_q;

    // Slow clock synchroniser plus history flop for rising-edge detection
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
        end else begin
            slow_s1 <= bus.i_slow_clk;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
        end
    end

    assign tick = slow_s2 & ~slow_s3;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= bus.i_btn;
            btn_s2 <= btn_s1;
        end
    end

    // A changed level is accepted on the tick that completes the required run;
    // a rising acceptance is what becomes the press pulse one cycle later.
    assign deb_accept  = tick && (btn_s2 != btn_stable) && (deb_cnt == DEB_LAST);
    assign rise_accept = deb_accept && btn_s2;

    // Tick-paced debouncer and registered press pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            btn_stable <= 1'b0;
            deb_cnt    <= '0;
            press      <= 1'b0;
        end else begin
            press <= rise_accept;
            if (tick) begin
                if (btn_s2 == btn_stable) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    btn_stable <= btn_s2;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end
        end
    end

`ifdef AUTO_OFF_EN
    localparam logic [15:0] IDLE_LAST = 16'(AUTO_OFF_TICKS - 1);

    logic [15:0] idle_cnt;

    // A rising acceptance on the timeout tick means a press is one cycle away;
    // the timeout is withheld so the press advances the level instead.
    assign timeout = tick && (state != MODE_OFF) && (idle_cnt == IDLE_LAST) && !rise_accept;

    // Idle counter: counts ticks spent lit without a press
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (press || (state == MODE_OFF) || timeout) begin
            idle_cnt <= '0;
        end else if (tick) begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Mode FSM state register; the state itself is the registered level output
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= MODE_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Mode FSM next-state: one step per press, illegal encodings fall back to OFF
    always_comb begin
        state_next = state;
        case (state)
            MODE_OFF: if (press) state_next = MODE_25;
            MODE_25:  if (press) state_next = MODE_50;
            MODE_50:  if (press) state_next = MODE_75;
            MODE_75:  if (press) state_next = MODE_100;
            MODE_100: if (press) state_next = MODE_OFF;
            default:  state_next = MODE_OFF;
        endcase
        if (!press && timeout) begin
            state_next = MODE_OFF;
        end
    end

    // Mode FSM output: expose the level code
    always_comb begin
        mode_out = state;
    end

    assign bus.o_mode = mode_out;

    // PWM next-state: counter steps per tick, duty reloads from the current
    // (pre-press) level only on the wrap tick
    always_comb begin
        wrap         = tick && (pwm_cnt == CNT_LAST);
        pwm_cnt_next = pwm_cnt;
        if (tick) begin
            pwm_cnt_next = wrap ? '0 : pwm_cnt + CNT_W'(1);
        end
        case (state)
            MODE_25:  duty_target = DUTY_25;
            MODE_50:  duty_target = DUTY_50;
            MODE_75:  duty_target = DUTY_75;
            MODE_100: duty_target = DUTY_100;
            default:  duty_target = '0;
        endcase
        duty_next = wrap ? duty_target : duty;
    end

    // PWM registers and registered LED drive
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt <= '0;
            duty    <= '0;
            light_q <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt_next;
            duty    <= duty_next;
            light_q <= (DUTY_W'(pwm_cnt_next) < duty_next);
        end
    end

    assign bus.o_light = light_q;

endmodule

// File: doc/stand_light_pwm_ctrl.md
Name: stand_light_pwm_ctrl

Overview:
Consumes the divided slow clock and a raw push-button, and drives the stand-light LED.
- Slow clock is sampled in the i_clk domain and turned into a one-cycle tick.
- Button is synchronised, debounced on ticks, and each press steps a 5-level brightness FSM.
- Selected level is rendered as tick-rate PWM on o_light.

Parameters:
PWM_PERIOD, 10, ticks per PWM period (>=4)
DEBOUNCE_TICKS, 4, consecutive ticks of a changed button level needed to accept it (>=1)
AUTO_OFF_TICKS, 1000, ticks without a press before auto-off (used only with AUTO_OFF_EN; <=65535)

Ports:
i_clk  input  1  system clock; all flops on rising edge
i_reset  input  1  asynchronous, active-high reset
i_slow_clk  input  1  divided clock from clock divider; treated as data, never as a clock
i_btn  input  1  raw button, active-high, asynchronous
o_light  output  1  PWM LED drive, registered
o_mode  output  3  current level: 0=OFF, 1=25%, 2=50%, 3=75%, 4=100%, registered

Behaviour:
- Reset (async assert, sync release):
  - All flops clear: o_light=0, o_mode=0, duty=0.
  - PWM, debounce and auto-off counters = 0.
  - Synchroniser flops = 0; debounced button = 0.
- Tick generation:
  - i_slow_clk passes through 2-flop sync (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3: exactly one i_clk cycle per slow-clock rising edge.
  - tick is high 2-3 i_clk cycles after i_slow_clk rises. Falling edges give no tick.
- Button:
  - i_btn passes through a 2-flop sync to give btn_s.
  - On each tick:
    - btn_s == btn_stable: deb_cnt <= 0.
    - btn_s != btn_stable: deb_cnt++. When the increment would reach DEBOUNCE_TICKS, btn_stable <= btn_s and deb_cnt <= 0.
  - press: registered one-cycle pulse on each btn_stable 0->1. Release generates nothing.
- Mode FSM (state = o_mode):
  - OFF -> L25 -> L50 -> L75 -> L100 -> OFF. Advances by one state per press pulse.
  - Values 5-7 are unreachable; if entered, the next cycle forces OFF.
- PWM:
  - pwm_cnt advances on tick over 0..PWM_PERIOD-1, wrapping to 0.
  - Duty target = (PWM_PERIOD*o_mode)/4, integer truncation. Defaults give 0, 2, 5, 7, 10.
  - The duty register loads the target only on a wrap tick (tick && pwm_cnt==PWM_PERIOD-1), so no partial periods.
  - o_light <= (pwm_cnt_next < duty_next), registered. Duty=0 gives constant 0; duty=PWM_PERIOD gives constant 1.
- Simultaneous press and wrap tick:
  - Duty loads from the pre-press o_mode.
  - The new level takes effect at the following wrap.
- Reset mid-period: output drops to 0 immediately; PWM restarts at count 0 with duty 0.
- Counter widths are sized with $clog2 of their limits. No counter ever exceeds its terminal value.

Optional Feature:
AUTO_OFF_EN
- Defined:
  - 16-bit idle counter increments on each tick while o_mode != OFF.
  - It clears on press and while in OFF.
  - When it reaches AUTO_OFF_TICKS, o_mode <= OFF and the counter clears.
  - If press and timeout fall in the same cycle, press wins: normal advance, counter cleared.
  - Duty still follows the wrap-load rule.
- Undefined: no idle counter is built; the level is held indefinitely.

Test Plan:
- Reset: assert i_reset mid-run with o_mode=3 -> o_light=0 and o_mode=0 in the same cycle; after release, no tick until the next i_slow_clk rise.
- Tick: i_slow_clk square wave, 200 i_clk period -> exactly one tick per 200 cycles, each 1 cycle wide.
- Debounce: toggle i_btn every 1 tick for 10 ticks, then hold 1 for 4 ticks -> exactly one press; o_mode 0->1; no press on release.
- Level cycling: 5 clean presses -> o_mode 1,2,3,4,0. Per level, o_light high count per 10-tick period = 2, 5, 7, 10, 0 (measured from the first full period after the change).
- Press on wrap tick: press lands in the wrap cycle at o_mode 1->2 -> that period uses duty 2; the next uses duty 5.
- AUTO_OFF_EN with AUTO_OFF_TICKS=20: o_mode=4, no press -> o_mode=0 on the 20th tick. Repeat with a press on tick 20 -> o_mode=0 via the FSM advance (4->OFF); idle counter cleared.
